imem_fetch_ctrl: RTL and testbench

Sequencer and owner of the single-port, word-addressed 1024x32 instruction memory. It arbitrates between two users: a program loader that writes words before or between runs, and the pipeline fetch stage that reads sequentially, with stall, branch redirect and halt. It drives the memory address and write controls and delivers registered instruction/PC pairs to IF/ID.

---
 rtl/imem_fetch_ctrl_if.sv | 39 +++
 rtl/imem_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Loader handshake and instruction memory bus of imem_fetch_ctrl.
// slave is the controller side; master is the loader/memory side.
interface imem_fetch_ctrl_if #(
  parameter int AW = 10
);
  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  modport slave (
    input  ld_valid,
    input  ld_addr,
    input  ld_data,
    input  ld_last,
    input  mem_rdata,
    output ld_ready,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  modport master (
    output ld_valid,
    output ld_addr,
    output ld_data,
    output ld_last,
    output mem_rdata,
    input  ld_ready,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory owner: arbitrates loader writes against
// sequential fetch with stall, branch flush and halt.
module imem_fetch_ctrl #(
  parameter int          DEPTH     = 1024,
  parameter int          AW        = 10,
  parameter int          BOOT_ADDR = 0,
  parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  stall,
  input  logic                  br_taken,
  input  logic [31:0]           br_target,
  imem_fetch_ctrl_if.slave      bus,
  output logic [31:0]           if_instr,
  output logic [31:0]           if_pc,
  output logic                  if_valid,
  output logic [1:0]            state,
  output logic [31:0]           fetch_count
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;

  localparam logic [AW-1:0] BOOT = AW'(BOOT_ADDR);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic          in_load;
  logic          in_run;

  // Upper address bits are architecturally ignored.
  logic unused_hi;
  assign unused_hi = ^{bus.ld_addr[31:AW], br_target[31:AW]};

  assign in_load = (state == S_LOAD);
  assign in_run  = (state == S_RUN);

  // Sequential increment with silent wrap at the top of memory.
  always_comb begin
    pc_next = pc + AW'(1);
    if (pc == LAST) pc_next = '0;
  end

  // Memory port steering: loader owns it in LOAD, fetch in RUN.
  always_comb begin
    bus.ld_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      in_load: begin
        bus.ld_ready  = 1'b1;
        bus.mem_we    = bus.ld_valid;
        bus.mem_addr  = bus.ld_addr[AW-1:0];
        bus.mem_wdata = bus.ld_data;
      end
      in_run: begin
        bus.mem_addr = pc;
      end
      default: ;
    endcase
  end

  // Mode sequencing and the registered IF/ID pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= BOOT;
      if_valid    <= 1'b0;
      if_instr    <= NOP_WORD;
      if_pc       <= '0;
      fetch_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.ld_valid) begin
            state <= S_LOAD;
          end else if (start) begin
            state       <= S_RUN;
            pc          <= BOOT;
            fetch_count <= '0;
          end
        end
        S_LOAD: begin
          if_valid <= 1'b0;
          if (bus.ld_valid && bus.ld_last) state <= S_IDLE;
        end
        S_RUN: begin
          if (bus.ld_valid) begin
            state    <= S_LOAD;
            if_valid <= 1'b0;
            if_instr <= NOP_WORD;
          end else if (halt) begin
            state    <= S_IDLE;
            if_valid <= 1'b0;
            if_instr <= NOP_WORD;
          end else if (br_taken) begin
            pc       <= br_target[AW-1:0];
            if_valid <= 1'b0;
            if_instr <= NOP_WORD;
          end else if (!stall) begin
            if_instr    <= bus.mem_rdata;
            if_pc       <= {{(32-AW){1'b0}}, pc};
            if_valid    <= 1'b1;
            pc          <= pc_next;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          if_valid <= 1'b0;
          if_instr <= NOP_WORD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus a randomized
// run compared against a spec-level model of the fetch sequence.
module tb_imem_fetch_ctrl;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic        clk = 1'b0;
  logic        rst, start, halt, stall, br_taken;
  logic [31:0] br_target;
  logic [31:0] if_instr, if_pc, fetch_count;
  logic        if_valid;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] la [$];
  logic [31:0] lq [$];

  imem_fetch_ctrl_if #(.AW(AW)) bus ();

  imem_fetch_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .BOOT_ADDR(0), .NOP_WORD(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .bus(bus), .if_instr(if_instr), .if_pc(if_pc),
    .if_valid(if_valid), .state(state), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; stall = 0; br_taken = 0; br_target = 0;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0; bus.ld_last = 0;
  endtask

  task automatic start_run();
    start = 1;
    cyc();
    start = 0;
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL start_run: state=%b want 10", state);
    end
  endtask

  task automatic stop_run();
    halt = 1;
    cyc();
    halt = 0;
  endtask

  task automatic load_q(input string nm);
    int n;
    n = la.size();
    bus.ld_valid = 1;
    bus.ld_addr = la[0];
    bus.ld_data = lq[0];
    bus.ld_last = (n == 1);
    cyc();
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL %s enter: state=%b want 01", nm, state);
    end
    for (int i = 0; i < n; i++) begin
      bus.ld_addr = la[i];
      bus.ld_data = lq[i];
      bus.ld_last = (i == n - 1);
      #1;
      checks++;
      if (bus.ld_ready !== 1'b1 || bus.mem_we !== 1'b1 ||
          bus.mem_addr !== AW'(la[i] % DEPTH) ||
          bus.mem_wdata !== lq[i]) begin
        errors++;
        $display("FAIL %s word%0d: rdy=%b we=%b a=%0d d=%h want 1 1 %0d %h",
                 nm, i, bus.ld_ready, bus.mem_we, bus.mem_addr,
                 bus.mem_wdata, la[i] % DEPTH, lq[i]);
      end
      ref_mem[la[i] % DEPTH] = lq[i];
      cyc();
    end
    bus.ld_valid = 0;
    bus.ld_last = 0;
    #1;
    checks++;
    if (state !== 2'b00 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL %s exit: state=%b we=%b want 00 0",
               nm, state, bus.mem_we);
    end
    la.delete();
    lq.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    #1;
    checks++;
    if (state !== 2'b00 || if_valid !== 0 || if_instr !== 0 ||
        if_pc !== 0 || fetch_count !== 0) begin
      errors++;
      $display("FAIL reset_regs: st=%b v=%b i=%h pc=%h cnt=%0d want 0",
               state, if_valid, if_instr, if_pc, fetch_count);
    end
    checks++;
    if (bus.ld_ready !== 0 || bus.mem_we !== 0 ||
        bus.mem_addr !== 0 || bus.mem_wdata !== 0) begin
      errors++;
      $display("FAIL reset_comb: rdy=%b we=%b a=%h d=%h want 0",
               bus.ld_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      la.push_back(32'(i));
      lq.push_back($urandom);
    end
    load_q("fill");
  endtask

  task automatic test_load_run();
    la = '{32'd0, 32'd1, 32'd2, 32'd3};
    lq = '{32'h11, 32'h22, 32'h33, 32'h44};
    load_q("load4");
    start_run();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.mem_addr !== AW'(k) || bus.mem_we !== 0) begin
        errors++;
        $display("FAIL run_addr%0d: a=%0d we=%b want %0d 0",
                 k, bus.mem_addr, bus.mem_we, k);
      end
      cyc();
      checks++;
      if (if_valid !== 1 || if_pc !== 32'(k) ||
          if_instr !== 32'h11 * 32'(k + 1) || fetch_count !== 32'(k + 1)) begin
        errors++;
        $display("FAIL run_fetch%0d: v=%b pc=%0d i=%h cnt=%0d want 1 %0d %h %0d",
                 k, if_valid, if_pc, if_instr, fetch_count,
                 k, 32'h11 * (k + 1), k + 1);
      end
    end
  endtask

  task automatic test_stall_branch();
    stop_run();
    start_run();
    cyc();
    cyc();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (if_valid !== 1 || if_pc !== 1 || if_instr !== ref_mem[1] ||
          fetch_count !== 2 || bus.mem_addr !== 2) begin
        errors++;
        $display("FAIL stall%0d: v=%b pc=%0d i=%h cnt=%0d a=%0d want 1 1 %h 2 2",
                 k, if_valid, if_pc, if_instr, fetch_count,
                 bus.mem_addr, ref_mem[1]);
      end
    end
    br_taken = 1;
    br_target = 7;
    cyc();
    br_taken = 0;
    stall = 0;
    checks++;
    if (if_valid !== 0 || if_instr !== 0) begin
      errors++;
      $display("FAIL br_flush: v=%b i=%h want 0 0", if_valid, if_instr);
    end
    cyc();
    checks++;
    if (if_valid !== 1 || if_pc !== 7 || if_instr !== ref_mem[7]) begin
      errors++;
      $display("FAIL br_first: v=%b pc=%0d i=%h want 1 7 %h",
               if_valid, if_pc, if_instr, ref_mem[7]);
    end
  endtask

  task automatic test_wrap();
    br_taken = 1;
    br_target = 1023;
    cyc();
    br_taken = 0;
    cyc();
    checks++;
    if (if_pc !== 1023 || if_instr !== ref_mem[1023]) begin
      errors++;
      $display("FAIL wrap_top: pc=%0d i=%h want 1023 %h",
               if_pc, if_instr, ref_mem[1023]);
    end
    cyc();
    checks++;
    if (if_pc !== 0 || if_instr !== ref_mem[0]) begin
      errors++;
      $display("FAIL wrap_zero: pc=%0d i=%h want 0 %h",
               if_pc, if_instr, ref_mem[0]);
    end
    br_taken = 1;
    br_target = 32'h00000405;
    cyc();
    br_taken = 0;
    cyc();
    checks++;
    if (if_pc !== 5 || if_instr !== ref_mem[5]) begin
      errors++;
      $display("FAIL br_trunc: pc=%0d i=%h want 5 %h",
               if_pc, if_instr, ref_mem[5]);
    end
  endtask

  task automatic test_preempt();
    bus.ld_valid = 1;
    bus.ld_addr = 1030;
    bus.ld_data = 32'hCAFEF00D;
    bus.ld_last = 1;
    cyc();
    checks++;
    if (state !== 2'b01 || if_valid !== 0) begin
      errors++;
      $display("FAIL preempt: st=%b v=%b want 01 0", state, if_valid);
    end
    checks++;
    if (bus.mem_addr !== 6 || bus.mem_we !== 1 || bus.ld_ready !== 1) begin
      errors++;
      $display("FAIL preempt_wr: a=%0d we=%b rdy=%b want 6 1 1",
               bus.mem_addr, bus.mem_we, bus.ld_ready);
    end
    ref_mem[6] = 32'hCAFEF00D;
    cyc();
    bus.ld_valid = 0;
    bus.ld_last = 0;
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL preempt_exit: st=%b want 00", state);
    end
    start_run();
    br_taken = 1;
    br_target = 6;
    cyc();
    br_taken = 0;
    cyc();
    checks++;
    if (if_pc !== 6 || if_instr !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL preempt_data: pc=%0d i=%h want 6 cafef00d",
               if_pc, if_instr);
    end
    stop_run();
  endtask

  task automatic test_simultaneous();
    start = 1;
    bus.ld_valid = 1;
    bus.ld_addr = 9;
    bus.ld_data = 32'h0BADBEEF;
    bus.ld_last = 1;
    cyc();
    start = 0;
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL ld_beats_start: st=%b want 01", state);
    end
    ref_mem[9] = 32'h0BADBEEF;
    cyc();
    bus.ld_valid = 0;
    bus.ld_last = 0;
    cyc();
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL start_dropped: st=%b want 00", state);
    end
    start_run();
    cyc();
    cyc();
    cyc();
    halt = 1;
    br_taken = 1;
    br_target = 20;
    cyc();
    halt = 0;
    br_taken = 0;
    checks++;
    if (state !== 2'b00 || if_valid !== 0 || if_instr !== 0) begin
      errors++;
      $display("FAIL halt_beats_br: st=%b v=%b i=%h want 00 0 0",
               state, if_valid, if_instr);
    end
  endtask

  task automatic test_random();
    bit running = 0;
    bit valid = 0;
    int pc = 0;
    logic [31:0] instr = 0;
    int ipc = 0;
    logic [31:0] cnt = 0;
    bit h, b, s;
    logic [31:0] tgt;
    for (int n = 0; n < 600; n++) begin
      h = ($urandom % 100) < 3;
      b = ($urandom % 100) < 10;
      s = ($urandom % 100) < 30;
      tgt = $urandom;
      halt = h;
      br_taken = b;
      stall = s;
      br_target = tgt;
      start = running ? $urandom % 2 : 1'b1;
      #1;
      if (running) begin
        checks++;
        if (bus.mem_addr !== AW'(pc)) begin
          errors++;
          $display("FAIL rnd_addr%0d: a=%0d want %0d", n, bus.mem_addr, pc);
        end
      end
      if (!running) begin
        running = 1;
        pc = 0;
        cnt = 0;
      end else if (h) begin
        running = 0;
        valid = 0;
        instr = 0;
      end else if (b) begin
        pc = int'(tgt % DEPTH);
        valid = 0;
        instr = 0;
      end else if (!s) begin
        instr = ref_mem[pc];
        ipc = pc;
        valid = 1;
        pc = (pc + 1) % DEPTH;
        cnt = cnt + 1;
      end
      cyc();
      checks++;
      if (state !== (running ? 2'b10 : 2'b00) || if_valid !== valid ||
          if_instr !== instr || fetch_count !== cnt ||
          (valid && if_pc !== 32'(ipc))) begin
        errors++;
        $display("FAIL rnd%0d: st=%b v=%b i=%h pc=%0d cnt=%0d want %0d %b %h %0d %0d",
                 n, state, if_valid, if_instr, if_pc, fetch_count,
                 running, valid, instr, ipc, cnt);
      end
    end
    idle_inputs();
    stop_run();
  endtask

  task automatic test_reset_midrun();
    start_run();
    for (int k = 0; k < 5; k++) cyc();
    checks++;
    if (bus.mem_addr !== 5 || fetch_count !== 5) begin
      errors++;
      $display("FAIL pre_rst: a=%0d cnt=%0d want 5 5", bus.mem_addr, fetch_count);
    end
    rst = 1;
    cyc();
    rst = 0;
    checks++;
    if (state !== 2'b00 || if_valid !== 0 || if_instr !== 0 ||
        fetch_count !== 0) begin
      errors++;
      $display("FAIL rst_midrun: st=%b v=%b i=%h cnt=%0d want 00 0 0 0",
               state, if_valid, if_instr, fetch_count);
    end
    start_run();
    cyc();
    checks++;
    if (if_pc !== 0 || if_instr !== ref_mem[0] || fetch_count !== 1) begin
      errors++;
      $display("FAIL rst_boot: pc=%0d i=%h cnt=%0d want 0 %h 1",
               if_pc, if_instr, fetch_count, ref_mem[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 0;
      ref_mem[i] = 0;
    end
    rst = 1;
    idle_inputs();
    test_reset();
    test_fill();
    test_load_run();
    test_stall_branch();
    test_wrap();
    test_preempt();
    test_simultaneous();
    test_random();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
